fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction buffer between the fetch stage and decode. Accepts fetch_data_t records (pc, raw_instr, valid) from fetch and presents them in order to decode.
- Decouples imem latency from decode/execute stalls, so fetch keeps running while decode is blocked.
- Discards all buffered records on a pipeline redirect (flush).

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), read/write pointer width; derived, not overridden.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  redirect from branch resolution; empties the queue.
- in_data  input  fetch_data_t  record from fetch. Only in_data.valid qualifies a push.
- in_ready  output  1  queue can accept a record this cycle; used by PC/fetch as a stall.
- out_data  output  fetch_data_t  head record to decode. Equals '0 when empty.
- out_valid  output  1  head record present.
- out_ready  input  1  decode consumes the head this cycle.
- count  output  PTR_W+1  occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH-entry register array, wr_ptr and rd_ptr of PTR_W bits, count of PTR_W+1 bits. Pointers wrap modulo DEPTH naturally.
- push = in_data.valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- in_ready = (count != DEPTH). Combinational from count only, with no dependence on out_ready. A full queue therefore never accepts a push, even in a cycle that pops.
- out_valid = (count != 0).
- out_data = mem[rd_ptr] when out_valid, else '0. out_data.valid equals out_valid.
- Latency: a record pushed at edge N is visible on out_data after edge N, i.e. one cycle later. No same-cycle bypass from input to output.
- Push only: write mem[wr_ptr], then wr_ptr+1 and count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop together (0<count<DEPTH): both pointers advance, count unchanged.
- Push and pop together with count==1: the new record becomes the head next cycle.
- Push to an empty queue while out_ready=1: no pop occurs (out_valid=0); the record is held.
- Flush: at the next edge wr_ptr=rd_ptr=0 and count=0. A simultaneous push and pop are both ignored.
- Flush has priority over everything except reset.
- While flush is high, in_ready may still be 1, but the push is dropped.
- Reset:
  - wr_ptr, rd_ptr and count are 0.
  - Array contents need not be cleared, because out_data is masked to '0 when empty.
  - Outputs after reset: out_valid=0, out_data='0, in_ready=1, count=0.
  - Reset asserted mid-operation behaves identically to flush plus state clear.
- Producer contract: one in_data.valid assertion per distinct instruction. Repeated presentation of the same pc is the producer's responsibility.
- Records with in_data.valid=0 (pc==0 idle, imem wait) are never stored.
- Assertions (sim only):
  - never push when count==DEPTH;
  - never pop when count==0;
  - count == (wr_ptr - rd_ptr) mod DEPTH, plus DEPTH when full.

Decomposition:
- Shared pipes package: fetch_data_t (already present). Add FETCH_QUEUE_DEPTH localparam for top-level instantiation.
- Shared common package: u1, u64 and related typedefs (already present).
- No sub-module. The pointer/count logic is small enough for one module, and a generic fifo sub-module is not warranted.

Test Plan:
- Reset, then hold in_data.valid=0 for 5 cycles -> out_valid=0, out_data='0, in_ready=1, count=0 throughout.
- Push pcs 0x80000000, 0x80000004, 0x80000008, 0x8000000C with out_ready=0 -> count reaches 4 and in_ready=0. A fifth push of 0x80000010 is dropped, and count stays 4.
- From full, set out_ready=1 for 4 cycles -> out_data.pc sequence 0x80000000, 0x80000004, 0x80000008, 0x8000000C, then out_valid=0.
- Steady stream with in_data.valid=1 and out_ready=1 each cycle, pcs incrementing by 4 -> count settles at 1, each record appears exactly one cycle after push, and order is preserved across a pointer wrap after more than DEPTH pushes.
- Queue holding 3 entries; assert flush together with push of 0x80001000 and out_ready=1 -> next cycle count=0 and out_valid=0. The following push of 0x80002000 emerges as the head with raw_instr intact.
- Assert reset with 2 entries queued while pushing -> next cycle count=0, out_valid=0, in_ready=1. Normal operation resumes on the cycle after reset drops.

Source files
------------

// File: rtl/common_pkg.sv
// Common scalar typedefs shared across the core pipeline.
// Pure type definitions, no logic.
// Imported by pipes_pkg and any block needing fixed-width aliases.
package common_pkg;

  typedef logic        u1;
  typedef logic [7:0]  u8;
  typedef logic [15:0] u16;
  typedef logic [31:0] u32;
  typedef logic [63:0] u64;

endpackage : common_pkg

// File: rtl/pipes_pkg.sv
// Inter-stage pipeline record types and stage sizing constants.
// Pure type definitions, no logic.
// fetch_data_t is the fetch -> decode record; valid qualifies the whole record.
package pipes_pkg;

  import common_pkg::*;

  // Record produced by fetch. pc == 0 / valid == 0 marks an idle or imem-wait cycle.
  typedef struct packed {
    u64 pc;
    u32 raw_instr;
    u1  valid;
  } fetch_data_t;

  // Default depth of the fetch -> decode instruction buffer.
  localparam int FETCH_QUEUE_DEPTH = 4;

  // Idle record used as the masked output of an empty buffer.
  function automatic fetch_data_t fetch_idle();
    fetch_data_t r;
    r = '0;
    return r;
  endfunction

endpackage : pipes_pkg

// File: rtl/fetch_queue.sv
// In-order instruction buffer between fetch and decode; flush discards all entries.
// Latency: a record pushed at edge N is presented to decode after edge N (no bypass).
// Backpressure: in_ready drops only when full, independent of out_ready; decode stalls hold the head.
module fetch_queue
  import common_pkg::*;
  import pipes_pkg::*;
#(
  parameter  int DEPTH = FETCH_QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  fetch_data_t      in_data,
  output logic             in_ready,
  output fetch_data_t      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  fetch_data_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // Handshake decode: readiness depends on occupancy only so a full queue never
  // accepts a push even while the head is being popped; flush kills both sides.
  always_comb begin
    in_ready  = (count != FULL_CNT);
    out_valid = (count != '0);
    push      = in_data.valid & in_ready & ~flush;
    pop       = out_valid & out_ready & ~flush;
  end

  // Head presentation: idle record when empty, so storage needs no reset.
  always_comb begin
    out_data = fetch_idle();
    if (out_valid) begin
      out_data       = mem[rd_ptr];
      out_data.valid = 1'b1;
    end
  end

  // Storage write: only accepted pushes touch the array.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointer and occupancy update; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Simulation-only structural checks on the pointer/count bookkeeping.
  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
    !(push && (count == FULL_CNT)));

  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
    !(pop && (count == '0)));

  a_count_ptrs: assert property (@(posedge clk) disable iff (reset)
    (count == FULL_CNT) ? (wr_ptr == rd_ptr)
                        : (count == {1'b0, PTR_W'(wr_ptr - rd_ptr)}));

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: accepted pushes are queued as expected records,
// and each decode consumption is compared against the queue head.
// One task per scenario; comparisons are inline in each task.
module tb_fetch_queue;

  import common_pkg::*;
  import pipes_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  fetch_data_t     in_data;
  logic            in_ready;
  fetch_data_t     out_data;
  logic            out_valid;
  logic            out_ready;
  logic [PTR_W:0]  count;

  int checks   = 0;
  int failures = 0;

  // scoreboard and per-cycle observations
  fetch_data_t sb[$];
  fetch_data_t exp_pop;
  logic        did_pop;
  fetch_data_t cur_out;
  logic        cur_vld;
  logic        cur_rdy;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    logic [31:0] lo;
    lo = pc[31:0];
    return lo ^ 32'h00A5_0013;
  endfunction

  // Drive one cycle of stimulus, advance the clock, update the reference model.
  // Outputs seen by the DUT's consumer during the cycle are captured before the edge.
  task automatic cycle(input logic v, input logic [63:0] pc, input logic rdy,
                       input logic fl, input logic rst);
    logic m_push;
    logic m_pop;
    in_data.pc        = pc;
    in_data.raw_instr = instr_of(pc);
    in_data.valid     = v;
    out_ready         = rdy;
    flush             = fl;
    reset             = rst;
    m_push = v && (sb.size() < DEPTH) && !fl;
    m_pop  = (sb.size() > 0) && rdy && !fl;
    #1;
    cur_out = out_data;
    cur_vld = out_valid;
    cur_rdy = in_ready;
    did_pop = 1'b0;
    @(posedge clk);
    #1;
    if (rst || fl) begin
      sb.delete();
    end else begin
      if (m_pop) begin
        exp_pop = sb.pop_front();
        did_pop = 1'b1;
      end
      if (m_push) begin
        sb.push_back(in_data);
      end
    end
  endtask

  task automatic test_reset();
    cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1 || count !== '0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got vld=%b data=%h rdy=%b cnt=%0d want 0/0/1/0",
                 i, out_valid, out_data, in_ready, count);
      end
    end
  endtask

  task automatic test_fill();
    logic [63:0] pcs [4];
    pcs[0] = 64'h8000_0000; pcs[1] = 64'h8000_0004;
    pcs[2] = 64'h8000_0008; pcs[3] = 64'h8000_000C;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, pcs[i], 1'b0, 1'b0, 1'b0);
      checks++;
      if (count !== (PTR_W+1)'(i + 1)) begin
        failures++;
        $display("FAIL fill_count i=%0d got=%0d want=%0d", i, count, i + 1);
      end
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_in_ready got=%b want=0", in_ready);
    end
    cycle(1'b1, 64'h8000_0010, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== (PTR_W+1)'(4) || out_data.pc !== 64'h8000_0000) begin
      failures++;
      $display("FAIL full_drop got cnt=%0d head=%h want cnt=4 head=80000000",
               count, out_data.pc);
    end
  endtask

  task automatic test_drain();
    logic [63:0] exp_pc [4];
    exp_pc[0] = 64'h8000_0000; exp_pc[1] = 64'h8000_0004;
    exp_pc[2] = 64'h8000_0008; exp_pc[3] = 64'h8000_000C;
    for (int i = 0; i < 4; i++) begin
      // first cycle also offers a push while full: must be refused despite the pop
      cycle(i == 0, 64'h8000_0014, 1'b1, 1'b0, 1'b0);
      checks++;
      if (!did_pop || cur_vld !== 1'b1 || cur_out !== exp_pop || cur_out.pc !== exp_pc[i]) begin
        failures++;
        $display("FAIL drain_head i=%0d got vld=%b pc=%h want pc=%h", i, cur_vld, cur_out.pc, exp_pc[i]);
      end
      checks++;
      if (count !== (PTR_W+1)'(3 - i)) begin
        failures++;
        $display("FAIL drain_count i=%0d got=%0d want=%0d", i, count, 3 - i);
      end
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL drain_empty got vld=%b data=%h want 0/0", out_valid, out_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] base;
    base = 64'h8000_0100;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, base + 64'(4 * i), 1'b1, 1'b0, 1'b0);
      if (i == 0) begin
        checks++;
        if (cur_vld !== 1'b0 || count !== (PTR_W+1)'(1)) begin
          failures++;
          $display("FAIL empty_push_no_pop got vld=%b cnt=%0d want 0/1", cur_vld, count);
        end
      end else begin
        checks++;
        if (!did_pop || cur_out !== exp_pop || cur_out.pc !== base + 64'(4 * (i - 1))) begin
          failures++;
          $display("FAIL stream_order i=%0d got pc=%h want pc=%h", i, cur_out.pc, base + 64'(4 * (i - 1)));
        end
      end
      checks++;
      if (count !== (PTR_W+1)'(1)) begin
        failures++;
        $display("FAIL stream_count i=%0d got=%0d want=1", i, count);
      end
    end
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (!did_pop || cur_out !== exp_pop || count !== '0) begin
      failures++;
      $display("FAIL stream_tail got pc=%h cnt=%0d want pc=%h cnt=0", cur_out.pc, count, exp_pop.pc);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 64'h8000_0800 + 64'(4 * i), 1'b0, 1'b0, 1'b0);
    end
    cycle(1'b1, 64'h8000_1000, 1'b1, 1'b1, 1'b0);
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL flush_empty got cnt=%0d vld=%b want 0/0", count, out_valid);
    end
    cycle(1'b1, 64'h8000_2000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data.pc !== 64'h8000_2000 ||
        out_data.raw_instr !== instr_of(64'h8000_2000) || out_data.valid !== 1'b1) begin
      failures++;
      $display("FAIL flush_resume got vld=%b pc=%h instr=%h want 1/80002000/%h",
               out_valid, out_data.pc, out_data.raw_instr, instr_of(64'h8000_2000));
    end
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (!did_pop || cur_out !== exp_pop || count !== '0) begin
      failures++;
      $display("FAIL flush_drain got pc=%h cnt=%0d want pc=%h cnt=0", cur_out.pc, count, exp_pop.pc);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 64'h8000_0A00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h8000_0A04, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h8000_0A08, 1'b1, 1'b0, 1'b1);
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid got cnt=%0d vld=%b rdy=%b want 0/0/1", count, out_valid, in_ready);
    end
    cycle(1'b1, 64'h8000_3000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (count !== (PTR_W+1)'(1) || out_data.pc !== 64'h8000_3000 || out_data !== sb[0]) begin
      failures++;
      $display("FAIL reset_resume got cnt=%0d pc=%h want 1/80003000", count, out_data.pc);
    end
    cycle(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (!did_pop || cur_out !== exp_pop || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_drain got pc=%h vld=%b want pc=%h vld=0", cur_out.pc, out_valid, exp_pop.pc);
    end
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_queue
